add_sub_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for wide add/subtract on one shared 4-bit adder slice.

---
 rtl/add_sub_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_add_sub_seq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/add_sub_seq_ctrl.sv
// rtl/add_sub_seq_ctrl.sv - multi-cycle wide add/subtract sequencer on a single 4-bit slice
module add_sub_seq_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] y,
    output logic         cout,
    output logic         ovf
);

    // Index width kept at least one bit so the single-nibble build still has a legal counter.
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            op_q, op_d;
    logic [W-1:0]    y_q, y_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [3:0]      x_nib;
    logic [3:0]      b_nib;
    logic [3:0]      z_nib;
    logic            ci;
    logic [4:0]      slice;
    logic            c3;
    logic            last_nib;

    // Nibble slice datapath plus next-state and registered-output logic for the sequencer.
    always_comb begin
        x_nib = 4'd0;
        b_nib = 4'd0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                x_nib = a_q[4*n +: 4];
                b_nib = b_q[4*n +: 4];
            end
        end
        // Subtract is a + ~b + 1, with the +1 entering as the carry-in of nibble 0.
        z_nib    = op_q ? ~b_nib : b_nib;
        ci       = (idx_q == '0) ? op_q : carry_q;
        slice    = {1'b0, x_nib} + {1'b0, z_nib} + {4'd0, ci};
        // Carry into bit 3 recovered from the sum bit; its XOR with c4 flags signed overflow.
        c3       = x_nib[3] ^ z_nib[3] ^ slice[3];
        last_nib = (idx_q == IW'(NIBBLES - 1));

        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    y_d     = '0;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IW'(n)) begin
                        y_d[4*n +: 4] = slice[3:0];
                    end
                end
                carry_d = slice[4];
                if (last_nib) begin
                    cout_d  = slice[4];
                    ovf_d   = c3 ^ slice[4];
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_add_sub_seq_ctrl.sv
// tb/tb_add_sub_seq_ctrl.sv - self-checking bench for add_sub_seq_ctrl
module tb_add_sub_seq_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;

    logic         start1;
    logic         op1;
    logic [3:0]   a1;
    logic [3:0]   b1;
    logic         busy1;
    logic         done1;
    logic [3:0]   y1;
    logic         cout1;
    logic         ovf1;

    int errors = 0;
    int checks = 0;

    add_sub_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .cout(cout), .ovf(ovf)
    );

    add_sub_seq_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .y(y1), .cout(cout1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic, result packed as {ovf, cout, y}.
    function automatic logic [17:0] ref_calc(input logic o, input logic [15:0] x, input logic [15:0] z);
        logic [16:0] s;
        logic        v;
        if (o) s = {1'b0, x} - {1'b0, z} + 17'h10000;
        else   s = {1'b0, x} + {1'b0, z};
        if (o) v = (x[15] != z[15]) && (s[15] != x[15]);
        else   v = (x[15] == z[15]) && (s[15] != x[15]);
        return {v, s[16], s[15:0]};
    endfunction

    // Called #1 after an edge; ends #1 after the done edge (the DONE cycle).
    task automatic do_op(input string tag, input logic o, input logic [15:0] x,
                         input logic [15:0] z, input bit noisy);
        logic [17:0] e;
        e = ref_calc(o, x, z);
        start = 1'b1; op = o; a = x; b = z;
        @(posedge clk); #1;
        start = noisy;
        if (noisy) begin
            op = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
        end
        chk({tag, " busy@accept"}, 32'(busy), 32'd1);
        for (int i = 1; i <= N; i++) begin
            @(posedge clk); #1;
            if (i < N) begin
                chk({tag, " run busy/done"}, {30'd0, busy, done}, 32'b10);
                if (noisy) begin
                    op = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
                end
            end else begin
                start = 1'b0;
                chk({tag, " done/busy"}, {30'd0, done, busy}, 32'b10);
                chk({tag, " y"}, 32'(y), 32'(e[15:0]));
                chk({tag, " cout/ovf"}, {30'd0, cout, ovf}, {30'd0, e[16], e[17]});
            end
        end
    endtask

    task automatic idle_check(input string tag, input int cycles, input logic [15:0] yexp);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk({tag, " idle busy/done"}, {30'd0, busy, done}, 32'd0);
            chk({tag, " y held"}, 32'(y), 32'(yexp));
        end
    endtask

    initial begin
        logic [17:0] e;
        logic        ro;
        logic [15:0] ra, rb;
        int          gap;

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        start1 = 1'b0; op1 = 1'b0; a1 = '0; b1 = '0;
        #2;
        chk("reset outs", {11'd0, busy, done, y, cout, ovf}, 32'd0);
        chk("reset outs n1", {23'd0, busy1, done1, y1, cout1, ovf1}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        do_op("add 1234+0fcd", 1'b0, 16'h1234, 16'h0FCD, 1'b0);
        idle_check("t1", 2, 16'h2201);
        do_op("sub 5-7", 1'b1, 16'h0005, 16'h0007, 1'b0);
        idle_check("t2", 1, 16'hFFFE);
        do_op("add ffff+1", 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        idle_check("t3a", 1, 16'h0000);
        do_op("add 7fff+1", 1'b0, 16'h7FFF, 16'h0001, 1'b0);
        idle_check("t3b", 1, 16'h8000);
        do_op("sub 8000-1", 1'b1, 16'h8000, 16'h0001, 1'b0);
        idle_check("t3c", 1, 16'h7FFF);

        do_op("noisy start", 1'b0, 16'hA5A5, 16'h1111, 1'b1);
        idle_check("t4a", 2, 16'hB6B6);

        do_op("b2b first", 1'b1, 16'h1000, 16'h0001, 1'b0);
        do_op("b2b second", 1'b0, 16'h4321, 16'h1234, 1'b0);
        idle_check("t4b", 1, 16'h5555);

        start = 1'b1; op = 1'b0; a = 16'h1357; b = 16'h2468;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async reset outs", {11'd0, busy, done, y, cout, ovf}, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post-reset no done", {30'd0, busy, done}, 32'd0);
        end
        do_op("after reset", 1'b0, 16'h1357, 16'h2468, 1'b0);
        idle_check("t5", 1, 16'h37BF);

        for (int k = 0; k < 24; k++) begin
            ro = 1'($urandom); ra = 16'($urandom); rb = 16'($urandom);
            if (k % 4 == 0) ra = 16'h8000 | ra;
            gap = $urandom_range(0, 2);
            do_op("random", ro, ra, rb, (k % 5 == 3));
            e = ref_calc(ro, ra, rb);
            if (gap > 0) idle_check("random gap", gap, e[15:0]);
        end

        start1 = 1'b1; op1 = 1'b0; a1 = 4'hF; b1 = 4'h1;
        @(posedge clk); #1;
        start1 = 1'b0;
        chk("n1 busy", {30'd0, busy1, done1}, 32'b10);
        @(posedge clk); #1;
        chk("n1 done", {30'd0, done1, busy1}, 32'b10);
        chk("n1 y/cout/ovf", {26'd0, y1, cout1, ovf1}, {26'd0, 4'h0, 1'b1, 1'b0});
        start1 = 1'b1; op1 = 1'b1; a1 = 4'h8; b1 = 4'h1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        chk("n1 sub 8-1", {25'd0, done1, y1, cout1, ovf1}, {25'd0, 1'b1, 4'h7, 1'b1, 1'b1});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
